// File: rtl/disp_cmd_parser.sv
// Display command byte-stream decoder: fetches bytes from the shared command
// register and turns them into cursor/attribute updates and text-buffer writes.
module disp_cmd_parser #(
  parameter int COLS   = 100,
  parameter int ROWS   = 75,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              has_data,
  input  logic [7:0]        rd_data,
  output logic              rd,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [15:0]       vram_wdata,
  output logic [7:0]        cur_attr,
  output logic              busy,
  output logic              cmd_err
);

  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0]        COL_MAX8  = 8'(COLS - 1);
  localparam logic [7:0]        ROW_MAX8  = 8'(ROWS - 1);
  localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CELLS - 1);

  typedef enum logic {F_WAIT, F_ACK} fetch_t;
  typedef enum logic [2:0] {D_OP, D_ATTR, D_COL, D_ROW, D_CHAR, D_CLEAR} dec_t;

  fetch_t f_state, f_next;
  dec_t   d_state, d_next;

  logic [7:0]        byte_q;
  logic [7:0]        attr_q;
  logic              err_q;
  logic              we_char_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [CW-1:0]     col_q, col_pend_q;
  logic [RW-1:0]     row_q;
  logic [ADDR_W-1:0] cur_lin;
  logic [CW-1:0]     col_clamp;
  logic [RW-1:0]     row_clamp;

  logic take, ack, clearing, clear_last, op_clear, op_bad;

  // Handshake: a byte is taken when has_data=1 is sampled in F_WAIT (never
  // while clearing); rd is high for the single following cycle, which is the
  // consume strobe. has_data is not looked at during that ack cycle.
  assign ack        = (f_state == F_ACK);
  assign clearing   = (d_state == D_CLEAR);
  assign clear_last = clearing && (addr_q == ADDR_LAST);
  assign op_clear   = ack && (d_state == D_OP) && (byte_q == 8'h04);
  assign op_bad     = ack && (d_state == D_OP) && (byte_q > 8'h04);

  assign cur_lin   = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign col_clamp = (int'(byte_q) >= COLS) ? CW'(COL_MAX8) : CW'(byte_q);
  assign row_clamp = (int'(byte_q) >= ROWS) ? RW'(ROW_MAX8) : RW'(byte_q);

  assign rd         = ack;
  assign busy       = clearing;
  assign vram_we    = we_char_q | clearing;
  assign vram_addr  = addr_q;
  assign vram_wdata = wdata_q;
  assign cur_attr   = attr_q;
  assign cmd_err    = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_state <= F_WAIT;
      d_state <= D_OP;
    end else begin
      f_state <= f_next;
      d_state <= d_next;
    end
  end

  always_comb begin
    f_next = f_state;
    take   = 1'b0;
    case (f_state)
      F_WAIT: begin
        if (has_data && !clearing) begin
          take   = 1'b1;
          f_next = F_ACK;
        end
      end
      F_ACK:   f_next = F_WAIT;
      default: f_next = F_WAIT;
    endcase
  end

  always_comb begin
    d_next = d_state;
    if (ack) begin
      case (d_state)
        D_OP: begin
          case (byte_q)
            8'h01:   d_next = D_ATTR;
            8'h02:   d_next = D_COL;
            8'h03:   d_next = D_CHAR;
            8'h04:   d_next = D_CLEAR;
            default: d_next = D_OP;
          endcase
        end
        D_COL:   d_next = D_ROW;
        D_ATTR,
        D_ROW,
        D_CHAR:  d_next = D_OP;
        default: d_next = d_state;
      endcase
    end
    if (clear_last) d_next = D_OP;
  end

  // Character writes are registered at the byte-sample edge so the write
  // cycle lines up with the rd cycle of the character byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q     <= 8'h00;
      attr_q     <= 8'h0F;
      err_q      <= 1'b0;
      we_char_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 16'h0000;
      col_q      <= '0;
      row_q      <= '0;
      col_pend_q <= '0;
    end else begin
      we_char_q <= 1'b0;
      if (take) begin
        byte_q <= rd_data;
        if (d_state == D_CHAR) begin
          we_char_q <= 1'b1;
          addr_q    <= cur_lin;
          wdata_q   <= {attr_q, rd_data};
        end
      end

      if (op_bad) err_q <= 1'b1;

      if (op_clear) begin
        addr_q  <= '0;
        wdata_q <= {attr_q, 8'h20};
      end

      if (ack) begin
        case (d_state)
          D_ATTR: attr_q <= byte_q;
          D_COL:  col_pend_q <= col_clamp;
          D_ROW: begin
            col_q <= col_pend_q;
            row_q <= row_clamp;
          end
          D_CHAR: begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
          default: ;
        endcase
      end

      // The clear walks the write address itself; addr_q doubles as counter.
      if (clearing) begin
        if (clear_last) begin
          col_q <= '0;
          row_q <= '0;
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_disp_cmd_parser.sv
// Directed bench for disp_cmd_parser: byte driver, write scoreboard and
// rd/busy timing monitor.
module tb_disp_cmd_parser;

  localparam int COLS   = 100;
  localparam int ROWS   = 75;
  localparam int ADDR_W = 13;
  localparam int CELLS  = COLS * ROWS;
  localparam int W      = ADDR_W + 16;

  logic              clk;
  logic              rst;
  logic              has_data;
  logic [7:0]        rd_data;
  logic              rd;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [15:0]       vram_wdata;
  logic [7:0]        cur_attr;
  logic              busy;
  logic              cmd_err;

  disp_cmd_parser #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .has_data   (has_data),
    .rd_data    (rd_data),
    .rd         (rd),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .cur_attr   (cur_attr),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           rd_cycles[$];
  logic         mon_en = 1'b0;
  logic         prev_rd = 1'b0;
  int           busy_cycles = 0;
  int           first_busy = -1;
  int           last_busy = -1;
  int           rd_in_busy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] wr(input int a, input logic [15:0] d);
    return {ADDR_W'(a), d};
  endfunction

  always @(posedge clk) cyc++;

  // scoreboard / monitor
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (vram_we) begin
        if (exp_q.size() == 0) chk("unexpected_write", {3'b0, vram_addr, vram_wdata}, 32'hFFFF_FFFF);
        else chk("write", {3'b0, vram_addr, vram_wdata}, {3'b0, exp_q.pop_front()});
        if (!busy) chk("char_we_with_rd", {31'b0, rd}, 32'd1);
      end
      if (busy) begin
        busy_cycles++;
        if (first_busy < 0) first_busy = cyc;
        last_busy = cyc;
        if (rd) rd_in_busy++;
      end
      if (rd) begin
        if (prev_rd) chk("rd_width", {31'b0, prev_rd}, 32'd0);
        rd_cycles.push_back(cyc);
      end
    end
    prev_rd = rd;
  end

  // driver tasks
  task automatic send(input logic [7:0] b);
    int waited;
    has_data = 1'b1;
    rd_data  = b;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (rd) break;
      waited++;
      if (waited > 10000) begin
        chk("rd_timeout", 32'd0, 32'd1);
        has_data = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    has_data = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    has_data = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int ack04, ack03;

  initial begin
    has_data = 1'b0;
    rd_data  = 8'h00;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rd", {31'b0, rd}, 32'd0);
    chk("rst_we", {31'b0, vram_we}, 32'd0);
    chk("rst_addr", {19'b0, vram_addr}, 32'd0);
    chk("rst_wdata", {16'b0, vram_wdata}, 32'd0);
    chk("rst_attr", {24'b0, cur_attr}, 32'h0F);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, cmd_err}, 32'd0);
    mon_en = 1'b1;

    // PUT_CHAR at home position, back-to-back bytes
    rd_cycles.delete();
    exp_q.push_back(wr(0, 16'h0F41));
    send(8'h03); send(8'h41); idle(4);
    chk("t1_rd_count", rd_cycles.size(), 32'd2);
    if (rd_cycles.size() >= 2) chk("t1_rd_gap", rd_cycles[1] - rd_cycles[0], 32'd2);
    chk("t1_drain", exp_q.size(), 32'd0);

    // NOP, SET_ATTR, SET_POS interrupted by long gaps, PUT_CHAR
    send(8'h00); send(8'h01); send(8'h1E);
    send(8'h02); idle(15); send(8'h05); idle(30); send(8'h02); idle(5);
    exp_q.push_back(wr(205, 16'h1E58));
    send(8'h03); send(8'h58); idle(4);
    chk("t2_attr", {24'b0, cur_attr}, 32'h1E);
    chk("t2_drain", exp_q.size(), 32'd0);

    // last cell, then wrap to top-left
    send(8'h02); send(8'h63); send(8'h4A);
    exp_q.push_back(wr(7499, 16'h1E21));
    exp_q.push_back(wr(0, 16'h1E22));
    send(8'h03); send(8'h21); send(8'h03); send(8'h22); idle(4);
    chk("t3_drain", exp_q.size(), 32'd0);

    // column and row clamp
    send(8'h02); send(8'hC8); send(8'hFF);
    exp_q.push_back(wr(7499, 16'h1E30));
    send(8'h03); send(8'h30); idle(4);
    chk("t4_drain", exp_q.size(), 32'd0);
    chk("t4_err_clear", {31'b0, cmd_err}, 32'd0);

    // CLEAR with the next opcode already waiting
    mon_en = 1'b0;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < CELLS; i++) exp_q.push_back(wr(i, 16'h0F20));
    busy_cycles = 0; first_busy = -1; last_busy = -1; rd_in_busy = 0;
    rd_cycles.delete();
    mon_en = 1'b1;
    send(8'h04);
    ack04 = (rd_cycles.size() > 0) ? rd_cycles[rd_cycles.size()-1] : -100;
    send(8'h03);
    ack03 = (rd_cycles.size() > 0) ? rd_cycles[rd_cycles.size()-1] : -100;
    exp_q.push_back(wr(0, 16'h0F41));
    send(8'h41); idle(4);
    chk("t5_busy_cycles", busy_cycles, CELLS);
    chk("t5_busy_start", first_busy - ack04, 32'd1);
    chk("t5_next_accept", ack03 - last_busy, 32'd2);
    chk("t5_rd_in_busy", rd_in_busy, 32'd0);
    chk("t5_drain", exp_q.size(), 32'd0);

    // unknown opcode, then asynchronous reset in the middle of a clear
    send(8'h7F); idle(2);
    chk("t6_err_set", {31'b0, cmd_err}, 32'd1);
    mon_en = 1'b0;
    send(8'h04); idle(200);
    chk("t6_busy_before", {31'b0, busy}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_we", {31'b0, vram_we}, 32'd0);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_err", {31'b0, cmd_err}, 32'd0);
    chk("t6_rst_rd", {31'b0, rd}, 32'd0);
    chk("t6_rst_addr", {19'b0, vram_addr}, 32'd0);
    chk("t6_rst_attr", {24'b0, cur_attr}, 32'h0F);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    exp_q.push_back(wr(0, 16'h0F41));
    send(8'h03); send(8'h41); idle(4);
    chk("t6_drain", exp_q.size(), 32'd0);
    chk("t6_busy_after", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/disp_cmd_parser.md
# disp_cmd_parser

Decodes the display command byte stream delivered through the shared command register and turns it into text-buffer writes. It consumes bytes with the shared register's has_data/rd/rd_data handshake. It tracks a cursor and a current attribute, and drives a single write port into the character video RAM that the pixel generator reads. The block sits directly downstream of the FIFO-read stage.

## Interface
Parameters:
- COLS, 100, text columns (800 px / 8)
- ROWS, 75, text rows (600 px / 8)
- ADDR_W, 13, video RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS

Ports:
- clk  in  1  system clock. One clock domain only.
- rst  in  1  reset, asynchronous, active-high
- has_data  in  1  shared register holds an unread byte
- rd_data  in  8  shared register byte; valid whenever has_data=1
- rd  out  1  one-cycle consume strobe to the shared register
- vram_we  out  1  video RAM write enable
- vram_addr  out  ADDR_W  cell address = row*COLS+col
- vram_wdata  out  16  {attr[7:0], char[7:0]}
- cur_attr  out  8  current attribute register
- busy  out  1  high while CLEAR is running
- cmd_err  out  1  sticky flag, set by an unknown opcode

## Operation
- Reset values: rd=0, vram_we=0, vram_addr=0, vram_wdata=0, cur_attr=8'h0F, busy=0, cmd_err=0. The cursor resets to col=0, row=0. The decoder resets to expecting an opcode.
- Fetch sub-FSM:
  - F_WAIT: if has_data=1 and not clearing, latch rd_data and go to F_ACK.
  - F_ACK: rd=1 for exactly this cycle, pass the byte to the decoder, return to F_WAIT.
  - has_data is never sampled in F_ACK.
- Decoder states: D_OP, D_ATTR, D_COL, D_ROW, D_CHAR, D_CLEAR.
- Opcodes, decoded in D_OP:
  - 8'h00 NOP: stay in D_OP.
  - 8'h01 SET_ATTR: go to D_ATTR. The next byte goes to cur_attr; return to D_OP.
  - 8'h02 SET_POS: go to D_COL, then D_ROW.
    - Column byte >= COLS clamps to COLS-1; row byte >= ROWS clamps to ROWS-1.
    - The cursor updates after the row byte; return to D_OP.
  - 8'h03 PUT_CHAR: go to D_CHAR.
    - The next byte is written at the cursor with data {cur_attr, byte}.
    - The cursor then advances; return to D_OP.
  - 8'h04 CLEAR: go to D_CLEAR.
    - Write {cur_attr, 8'h20} to addresses 0..COLS*ROWS-1 in ascending order, one per cycle.
    - Then set the cursor to (0,0) and return to D_OP.
  - Any other value: set cmd_err=1 and stay in D_OP. The byte is consumed.
- Cursor advance:
  - col+1.
  - If col==COLS-1: col=0, row+1.
  - If additionally row==ROWS-1: row=0 (wrap to top-left). No scrolling.
- Address arithmetic:
  - vram_addr is the row*COLS+col value, ADDR_W bits, never >= COLS*ROWS.
  - Tracking an incremental linear address is allowed if the result is identical.
- A multi-byte command interrupted by arbitrarily long gaps (has_data=0) stays in its partial state indefinitely.

## Timing
- Byte accept:
  - has_data=1 sampled in F_WAIT at edge E.
  - rd=1 in the cycle after E.
  - The earliest next sample of has_data is at edge E+2.
  - Maximum rate is one byte per 2 clocks.
- PUT_CHAR: vram_we=1 for exactly one cycle, in the same cycle rd acks the char byte. That cycle carries the address and data for the pre-advance cursor. The cursor advances at the end of that cycle.
- CLEAR:
  - busy=1 and vram_we=1 start in the cycle after the CLEAR opcode's ack cycle.
  - Both hold for COLS*ROWS consecutive cycles; busy falls with the last write.
  - rd stays 0 throughout. has_data may remain high, and is first sampled the cycle after busy falls.
- SET_ATTR takes effect for a PUT_CHAR or CLEAR whose opcode is accepted after the attribute byte's ack cycle.
- vram_we=0 in every cycle not listed above. vram_addr and vram_wdata hold their last values when not writing.
- Asynchronous reset mid-command or mid-CLEAR:
  - All outputs return to reset values immediately.
  - The partial command is discarded.
  - After reset release, the next byte is treated as an opcode.

## Test plan
- Reset, then bytes 03 41 → one write: addr 0, data 16'h0F41. The cursor moves to (1,0). rd pulses twice, each one cycle wide, with 2-cycle spacing.
- 01 1E, 02 05 02, 03 58 → write: addr 2*100+5=205, data 16'h1E58. cur_attr=8'h1E.
- 02 63 4A, then 03 21 03 22 → writes at addr 7499, then at addr 0 (wrap to top-left).
- 02 C8 FF, then 03 30 → column and row clamp. The write lands at addr 7499.
- 04 with has_data held high and the next byte 03 queued → 7500 consecutive writes:
  - addresses 0..7499, data 16'h0F20, busy high throughout;
  - no rd during the clear; the queued 03 is accepted afterwards with the cursor at (0,0).
- Byte 7F, then rst pulsed during a 7500-cycle clear → cmd_err=1 after 7F. The pulse immediately zeroes vram_we, busy and cmd_err. After release, 03 41 writes to addr 0.
